// File: rtl/serial_nibble_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_rx
// Description : Strobe-timed serial frame receiver (start, data, parity, stop)
//               that presents good words in parallel with a one-cycle VALID.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_rx #(
    parameter int WIDTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             CLOCK,
    input  logic             RST,
    input  logic             BIT_EN,
    input  logic             SIN,
    output logic [0:WIDTH-1] DATA_OUT,
    output logic             VALID,
    output logic             PERR,
    output logic             FERR,
    output logic             BUSY
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [0:WIDTH-1] shift_q, shift_d;
    logic [0:WIDTH-1] data_q, data_d;
    logic             mism_q, mism_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            mism_q  <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            mism_q  <= mism_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Pulses default low every cycle so they last one clock regardless of BIT_EN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        mism_d  = mism_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (BIT_EN) begin
            case (state_q)
                S_IDLE: begin
                    if (!SIN) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        mism_d  = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d[cnt_q] = SIN;
                    if (cnt_q == IW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
                S_PAR: begin
                    mism_d  = ((^shift_q) ^ SIN) != PARITY_ODD[0];
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    perr_d  = mism_q;
                    ferr_d  = !SIN;
                    if (SIN && !mism_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign DATA_OUT = data_q;
    assign VALID    = valid_q;
    assign PERR     = perr_q;
    assign FERR     = ferr_q;
    assign BUSY     = (state_q != S_IDLE);

endmodule
`default_nettype wire
